sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 117 +++++++++++
 tb/tb_sync_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-toggle full/empty detection and a one-cycle
// error pulse for every rejected request.
module sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             error_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic                  wr_toggle_r;
    logic                  rd_toggle_r;
    logic                  wr_toggle_nxt_s;
    logic                  rd_toggle_nxt_s;
    logic [WIDTH-1:0]      rdata_r;
    logic                  error_r;
    logic                  ptr_eq_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  reject_s;

    // Equal pointers mean empty or full; the wrap toggles tell which.
    assign ptr_eq_s    = (wr_ptr_r == rd_ptr_r);
    assign empty_s     = ptr_eq_s && (wr_toggle_r == rd_toggle_r);
    assign full_s      = ptr_eq_s && (wr_toggle_r != rd_toggle_r);
    assign wr_accept_s = wr_en_i && !full_s;
    assign rd_accept_s = rd_en_i && !empty_s;
    assign reject_s    = (wr_en_i && full_s) || (rd_en_i && empty_s);

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign error_o = error_r;
    assign rdata_o = rdata_r;

    // Next write pointer and toggle.
    always_comb begin
        wr_ptr_nxt_s    = wr_ptr_r;
        wr_toggle_nxt_s = wr_toggle_r;
        if (wr_accept_s) begin
            if (wr_ptr_r == LAST_IDX) begin
                wr_ptr_nxt_s    = '0;
                wr_toggle_nxt_s = ~wr_toggle_r;
            end else begin
                wr_ptr_nxt_s    = wr_ptr_r + PTR_ONE;
                wr_toggle_nxt_s = wr_toggle_r;
            end
        end else begin
            wr_ptr_nxt_s    = wr_ptr_r;
            wr_toggle_nxt_s = wr_toggle_r;
        end
    end

    // Next read pointer and toggle.
    always_comb begin
        rd_ptr_nxt_s    = rd_ptr_r;
        rd_toggle_nxt_s = rd_toggle_r;
        if (rd_accept_s) begin
            if (rd_ptr_r == LAST_IDX) begin
                rd_ptr_nxt_s    = '0;
                rd_toggle_nxt_s = ~rd_toggle_r;
            end else begin
                rd_ptr_nxt_s    = rd_ptr_r + PTR_ONE;
                rd_toggle_nxt_s = rd_toggle_r;
            end
        end else begin
            rd_ptr_nxt_s    = rd_ptr_r;
            rd_toggle_nxt_s = rd_toggle_r;
        end
    end

    // Control state, read data and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            wr_toggle_r <= 1'b0;
            rd_toggle_r <= 1'b0;
            rdata_r     <= '0;
            error_r     <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_toggle_r <= wr_toggle_nxt_s;
            rd_toggle_r <= rd_toggle_nxt_s;
            error_r     <= reject_s;
            if (rd_accept_s) begin
                rdata_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Storage array; deliberately not reset, stale words are unreachable after pointer reset.
    always_ff @(posedge clk_i) begin
        if (wr_accept_s && !rst_i) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus pushes expected post-edge state,
// a monitor pops and compares one record per clock.
module tb_sync_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] rdata;
        logic             err;
        logic             full;
        logic             empty;
        string            tag;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             wr_en_i = 1'b0;
    logic             rd_en_i = 1'b0;
    logic             full_o;
    logic             empty_o;
    logic             error_o;
    logic [WIDTH-1:0] rdata_o;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] last_rdata = '0;
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wdata_i (wdata_i),
        .wr_en_i (wr_en_i),
        .rd_en_i (rd_en_i),
        .full_o  (full_o),
        .empty_o (empty_o),
        .error_o (error_o),
        .rdata_o (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one clock of stimulus and queue the state expected right after its edge.
    task automatic cycle(input logic rst, input logic wr, input logic [WIDTH-1:0] wd,
                         input logic rd, input string tag);
        exp_t e;
        logic pre_full;
        logic pre_empty;
        @(negedge clk_i);
        rst_i   = rst;
        wr_en_i = wr;
        wdata_i = wd;
        rd_en_i = rd;
        pre_full  = (model_q.size() == DEPTH);
        pre_empty = (model_q.size() == 0);
        if (rst) begin
            model_q.delete();
            last_rdata = '0;
            e.err = 1'b0;
        end else begin
            e.err = (wr && pre_full) || (rd && pre_empty);
            if (rd && !pre_empty) last_rdata = model_q.pop_front();
            if (wr && !pre_full) model_q.push_back(wd);
        end
        e.rdata = last_rdata;
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic wr_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, tag);
    endtask

    task automatic rd_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, tag);
    endtask

    task automatic both_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, WIDTH'($urandom_range(0, 15)), 1'b1, tag);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, " rdata"}, rdata_o, mon_e.rdata);
            check({mon_e.tag, " error"}, {3'b000, error_o}, {3'b000, mon_e.err});
            check({mon_e.tag, " full"},  {3'b000, full_o},  {3'b000, mon_e.full});
            check({mon_e.tag, " empty"}, {3'b000, empty_o}, {3'b000, mon_e.empty});
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, "reset");
        cycle(1'b0, 1'b0, '0, 1'b0, "idle");

        wr_n(17, "fill");
        cycle(1'b0, 1'b0, '0, 1'b0, "err_clear");
        rd_n(17, "drain");
        cycle(1'b0, 1'b0, '0, 1'b0, "hold");

        wr_n(10, "wrap_w10");
        rd_n(10, "wrap_r10");
        wr_n(16, "wrap_w16");
        rd_n(16, "wrap_r16");

        wr_n(5, "sim_pre");
        both_n(8, "sim_mid");
        wr_n(11, "sim_fill");
        both_n(1, "sim_full");
        wr_n(1, "sim_refill");
        both_n(1, "sim_full2");
        rd_n(16, "sim_drain");
        both_n(1, "sim_empty");
        rd_n(1, "sim_last");

        wr_n(7, "mid_w7");
        cycle(1'b1, 1'b0, '0, 1'b0, "mid_rst");
        rd_n(1, "post_rst_rd");
        cycle(1'b0, 1'b1, 4'hA, 1'b0, "post_w1");
        cycle(1'b0, 1'b1, 4'h5, 1'b1, "post_w2");
        rd_n(2, "post_rd");

        @(negedge clk_i);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
